// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream consumer.
package fifo_rd_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} rd_state_e;
  localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry in-order buffer that absorbs the FIFO read latency; head is always visible.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int d_width = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  logic [d_width-1:0] din,
  output logic [d_width-1:0] head,
  output logic [1:0]         occ
);
  logic [BUF_DEPTH-1:0][d_width-1:0] mem;
  logic                              hd_ptr, tl_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      hd_ptr <= 1'b0;
      tl_ptr <= 1'b0;
      occ    <= 2'd0;
    end else if (clear) begin
      hd_ptr <= 1'b0;
      tl_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[tl_ptr] <= din;
        tl_ptr      <= ~tl_ptr;
      end
      if (pop) hd_ptr <= ~hd_ptr;
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: ;
      endcase
    end
  end

  assign head = mem[hd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && occ == 2'(BUF_DEPTH)));
endmodule

// File: rtl/fifo_stream_reader.sv
// Read-domain consumer: pops the async FIFO and streams words out on valid/ready.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int d_width   = 16,
  parameter int cnt_width = 16
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  output logic                 rd_en,
  input  logic [d_width-1:0]   rd_data,
  output logic [d_width-1:0]   m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  input  logic                 flush,
  output logic                 flush_done,
  output logic [cnt_width-1:0] word_count,
  output logic                 busy
);
  rd_state_e  state, state_nxt;
  logic       inflight, done_seen;
  logic       pop, push, clear;
  logic [1:0] occ;
  logic [2:0] pending;

  assign m_valid = (state == RUN) && (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  assign push    = inflight && (state == RUN);
  // The flush edge itself discards the buffer; the pop on that edge still completes.
  assign clear   = (state != RUN) || flush;
  assign pending = {1'b0, occ} + {2'b0, inflight};
  assign busy    = (occ != 2'd0) || inflight || (state != RUN);

  fifo_rd_skid_buf #(.d_width(d_width)) u_buf (
    .clk   (Clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (rd_data),
    .head  (m_data),
    .occ   (occ)
  );

  always_comb begin
    state_nxt  = state;
    rd_en      = 1'b0;
    flush_done = 1'b0;
    case (state)
      RUN: begin
        rd_en = !fifo_empty && (pending <= 3'd1 + {2'b0, pop});
        if (flush) state_nxt = DRAIN;
      end
      DRAIN: begin
        rd_en = !fifo_empty;
        if (fifo_empty && !inflight) state_nxt = DONE;
      end
      DONE: begin
        flush_done = !done_seen;
        if (!flush) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (reset) rd_en = 1'b0;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      inflight   <= 1'b0;
      done_seen  <= 1'b0;
      word_count <= '0;
    end else begin
      state     <= state_nxt;
      inflight  <= rd_en;
      done_seen <= (state == DONE);
      if (pop) word_count <= word_count + 1'b1;
    end
  end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer for the team's Async_FIFO read port, in the read clock domain.
- Pops words with rd_en and absorbs the FIFO's one-cycle read latency in a 2-entry output buffer.
- Presents popped words on a valid/ready stream at full throughput, one word per cycle.
- Also counts delivered words and supports a flush that drains and discards the FIFO contents.

Parameters:
- d_width, 16, data word width; must match the FIFO d_width.
- cnt_width, 16, width of the delivered-word counter.

Ports:
- Clk  in  1  read-domain clock; the same clock as the FIFO rd_Clk.
- reset  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag, read domain.
- rd_en  out  1  FIFO read strobe.
- rd_data  in  d_width  FIFO read data, valid one Clk after a cycle with rd_en=1.
- m_data  out  d_width  output stream data.
- m_valid  out  1  output stream valid.
- m_ready  in  1  downstream accept.
- flush  in  1  level request to discard all buffered and FIFO data.
- flush_done  out  1  one-cycle pulse when the flush is complete.
- word_count  out  cnt_width  number of words accepted downstream.
- busy  out  1  high when occupancy, in-flight read or state is not idle.

Behaviour:
- Reset (asynchronous, active-high): all outputs and all state are cleared immediately.
  - rd_en=0, m_valid=0, m_data=0, flush_done=0, word_count=0, busy=0.
  - occ=0, inflight=0, state=RUN.
- Reset asserted mid-operation: the in-flight word is lost. That is acceptable because the FIFO is reset alongside.
- Internal state:
  - occ: 0..2 words held in the 2-entry buffer.
  - inflight: a read was issued last cycle, so rd_data lands this cycle.
- pop = m_valid && m_ready.
- rd_en is combinational:
  - rd_en = (state==RUN) && !fifo_empty && (occ + inflight - pop <= 1).
  - Never assert rd_en while fifo_empty=1.
  - Steady state (occ=1, inflight=1, pop=1) sustains one word per cycle.
- inflight <= rd_en, registered.
- Write into the buffer: when inflight=1 in state RUN, capture rd_data at the tail.
- Buffer order:
  - Strict FIFO order; m_data is always the head entry.
  - m_valid = (occ != 0).
  - m_data and m_valid are stable while m_valid && !m_ready.
- Capture and pop in the same cycle: occ is unchanged and the head advances.
  - With occ=1 the captured word becomes the head on the next cycle.
- Overflow is impossible by the rd_en rule. If occ==2 and a capture occurs, it is a design error and an assertion must fire.
- word_count increments on every pop and wraps modulo 2^cnt_width.
- State machine:
  - RUN: normal operation. flush=1 moves to DRAIN on the next edge.
  - DRAIN:
    - occ is cleared and m_valid is forced to 0.
    - rd_en = !fifo_empty, every cycle.
    - Returning words are discarded and word_count is not incremented.
    - When fifo_empty=1 and inflight=0, move to DONE.
  - DONE: flush_done=1 for exactly one cycle.
    - If flush is still high, stay in DONE with flush_done low, and return to RUN when flush drops.
    - If flush is low, go to RUN.
- flush asserted while m_valid && m_ready: that final pop still counts, and the buffer is discarded afterwards.
- flush while the FIFO is already empty and nothing is in flight: DRAIN lasts 1 cycle, then the DONE pulse.
- m_ready has no influence on rd_en in DRAIN or DONE.

Decomposition:
- Package fifo_rd_pkg holds:
  - the state enum: RUN=2'd0, DRAIN=2'd1, DONE=2'd2;
  - the constant BUF_DEPTH=2.
- One sub-module: fifo_rd_skid_buf, the 2-entry data buffer with head/tail pointers and occ.
  - Inputs: push, pop, clear.
  - Outputs: head data, occ.
- The top level holds the FSM, the rd_en logic, inflight and word_count.

Test Plan:
- Reset then idle, fifo_empty=1 -> rd_en never asserts; m_valid=0, word_count=0, busy=0.
- Write 50 words 0..49 into the FIFO with m_ready=1 -> m_data sequence is 0..49 in order at one word per Clk after the first word; word_count=50.
- Same 50 words, m_ready toggling 1/0 -> no loss or duplication; m_data holds while stalled; rd_en never asserts when occ+inflight would exceed 2.
- m_ready=0 for 20 cycles with 10 words in the FIFO -> occ saturates at 2 and exactly 2 rd_en pulses occur; the remaining 8 are read after m_ready rises.
- 30 words in the FIFO, assert flush for 1 cycle -> all 30 are drained with rd_en, m_valid stays 0, word_count unchanged, a single flush_done pulse, then RUN; a subsequent word 619 is delivered normally.
- Reset asserted mid-stream with occ=2 -> all outputs are 0 within the same cycle, asynchronously; after release, operation resumes from an empty state.
